crc_arb_seq: RTL and testbench

CRC_ARB_SEQ -- requirements
Module: crc_arb_seq

---
 rtl/crc_arb_seq_pkg.sv | 15 +
 rtl/crc_arb_seq_crc_step.sv | 23 ++
 rtl/crc_arb_seq.sv | 126 ++++++++++++
 tb/tb_crc_arb_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_arb_seq_pkg.sv
// Shared types and sizing helpers for the two-port CRC arbiter/sequencer.
package crc_arb_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Codeword length: data bits followed by the CRC field (poly width minus one).
    function automatic int crc_len(input int wcode, input int wpoly);
        return wcode + wpoly - 1;
    endfunction

endpackage

// File: rtl/crc_arb_seq_crc_step.sv
// One bit of MSB-first polynomial division. Purely combinational.
module crc_step #(
    parameter int WPOLY = 4
) (
    input  logic [WPOLY-2:0] rem,
    input  logic             code_bit,
    input  logic [WPOLY-1:0] poly,
    output logic [WPOLY-2:0] rem_next
);

    // The polynomial MSB is implicitly 1 and is absorbed by the shift-out of rem's top bit.
    logic unused_poly_msb;
    assign unused_poly_msb = poly[WPOLY-1];

    // Shift in the next codeword bit, subtract the generator when a 1 falls off the top.
    always_comb begin
        rem_next = {rem[WPOLY-3:0], code_bit};
        if (rem[WPOLY-2]) begin
            rem_next = rem_next ^ poly[WPOLY-2:0];
        end
    end

endmodule

// File: rtl/crc_arb_seq.sv
// Two-port round-robin CRC generate/check sequencer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | offering o_ready to the arbitration winner, waiting for a request
// ST_SHIFT | dividing the latched codeword, one bit per cycle, MSB first
// ST_DONE  | result presented, held until the consumer accepts it
module crc_arb_seq
    import crc_arb_seq_pkg::*;
#(
    parameter int WCODE = 5,
    parameter int WPOLY = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WPOLY-1:0] i_poly,
    input  logic [1:0]       i_valid,
    output logic [1:0]       o_ready,
    input  logic [WCODE-1:0] i_data0,
    input  logic [WCODE-1:0] i_data1,
    input  logic [WPOLY-2:0] i_crc0,
    input  logic [WPOLY-2:0] i_crc1,
    input  logic [1:0]       i_chk,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic             o_res_id,
    output logic [WPOLY-2:0] o_res_crc,
    output logic             o_res_err
);

    localparam int LEN  = crc_len(WCODE, WPOLY);
    localparam int CW   = $clog2(LEN + 1);
    localparam int WCRC = WPOLY - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    state_t           state_q;
    logic [LEN-1:0]   code_q;
    logic [WPOLY-1:0] poly_q;
    logic [WCRC-1:0]  rem_q;
    logic [WCRC-1:0]  rem_nxt;
    logic [CW-1:0]    cnt_q;
    logic             id_q;
    logic             chk_q;
    logic             last_q;

    logic             sel;
    logic             accept;
    logic             chk_sel;
    logic [WCODE-1:0] data_sel;
    logic [WCRC-1:0]  crc_field;

    // Round-robin pick: a lone requester wins, otherwise the port not granted last time.
    always_comb begin
        sel = ~last_q;
        if (i_valid == 2'b01) begin
            sel = 1'b0;
        end else if (i_valid == 2'b10) begin
            sel = 1'b1;
        end
    end

    // Ready is gated by reset so nothing is offered while the block is held in reset.
    assign o_ready   = (state_q == ST_IDLE && i_rst_n) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = |(i_valid & o_ready);
    assign data_sel  = sel ? i_data1 : i_data0;
    assign chk_sel   = i_chk[sel];
    // Generate mode divides data followed by zeros, so the incoming CRC field is ignored.
    assign crc_field = chk_sel ? (sel ? i_crc1 : i_crc0) : '0;

    crc_step #(.WPOLY(WPOLY)) u_step (
        .rem      (rem_q),
        .code_bit (code_q[LEN-1]),
        .poly     (poly_q),
        .rem_next (rem_nxt)
    );

    // Sequencer: latch the granted request, shift LEN bits, hold the result until taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            poly_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            chk_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        code_q  <= {data_sel, crc_field};
                        poly_q  <= i_poly;
                        id_q    <= sel;
                        chk_q   <= chk_sel;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        last_q  <= sel;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    rem_q  <= rem_nxt;
                    code_q <= {code_q[LEN-2:0], 1'b0};
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Result outputs are forced to zero whenever no result is being presented.
    assign o_res_valid = (state_q == ST_DONE);
    assign o_res_crc   = o_res_valid ? rem_q : '0;
    assign o_res_err   = o_res_valid & chk_q & (|rem_q);
    assign o_res_id    = o_res_valid & id_q;

endmodule

// File: tb/tb_crc_arb_seq.sv
// Directed bench for crc_arb_seq with default parameters (WCODE=5, WPOLY=4).
module tb_crc_arb_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] poly;
    logic [1:0] valid;
    logic [1:0] ready;
    logic [4:0] data0, data1;
    logic [2:0] crc0, crc1;
    logic [1:0] chk;
    logic       res_valid;
    logic       res_ready;
    logic       res_id;
    logic [2:0] res_crc;
    logic       res_err;

    int n_cmp = 0;
    int n_err = 0;

    crc_arb_seq dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_poly      (poly),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_data0     (data0),
        .i_data1     (data1),
        .i_crc0      (crc0),
        .i_crc1      (crc1),
        .i_chk       (chk),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_id    (res_id),
        .o_res_crc   (res_crc),
        .o_res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_crc"},   res_crc,   0);
        check({tag, "_res_err"},   res_err,   0);
        check({tag, "_res_id"},    res_id,    0);
    endtask

    // Present a request on port p, confirm it is offered, and step past the acceptance edge.
    task automatic start_req(input int p, input logic c, input logic [4:0] d,
                             input logic [2:0] f, input logic [3:0] pl);
        poly = pl;
        if (p == 0) begin
            data0 = d; crc0 = f; chk[0] = c; valid = 2'b01;
        end else begin
            data1 = d; crc1 = f; chk[1] = c; valid = 2'b10;
        end
        #1;
        check("ready_grant", ready, (p == 0) ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        valid = 2'b00;
        check("ready_busy", ready, 2'b00);
    endtask

    // Cycle 1 is the cycle right after the acceptance edge; the result is due in cycle 9.
    task automatic wait_done(input string tag);
        int cyc = 1;
        while (!res_valid && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 9);
    endtask

    task automatic check_res(input string tag, input logic [2:0] ec, input logic ee, input logic ei);
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_crc"},   res_crc,   ec);
        check({tag, "_err"},   res_err,   ee);
        check({tag, "_id"},    res_id,    ei);
    endtask

    task automatic release_res(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_idle_outputs(tag);
        check({tag, "_ready_back"}, (ready != 2'b00), 1);
    endtask

    logic       seen;
    int         n_res;
    logic       ids [4];
    logic [2:0] crcs[4];

    initial begin
        rst_n = 1'b0; poly = 4'b1011; valid = 2'b00; data0 = '0; data1 = '0;
        crc0 = '0; crc1 = '0; chk = 2'b00; res_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 2'b00);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        #1;
        check("post_rst_ready_port0", ready, 2'b01);

        // Port 0 generate; nonzero CRC field must be ignored
        start_req(0, 1'b0, 5'b11010, 3'b111, 4'b1011);
        wait_done("gen0");
        check_res("gen0", 3'b010, 1'b0, 1'b0);
        release_res("gen0_rel");

        // Port 1 check, good CRC
        start_req(1, 1'b1, 5'b11010, 3'b010, 4'b1011);
        wait_done("chk1_ok");
        check_res("chk1_ok", 3'b000, 1'b0, 1'b1);
        release_res("chk1_ok_rel");

        // Port 1 check, bad CRC
        start_req(1, 1'b1, 5'b11010, 3'b011, 4'b1011);
        wait_done("chk1_bad");
        check_res("chk1_bad", 3'b001, 1'b1, 1'b1);
        release_res("chk1_bad_rel");

        // Port 1 generate, different data: x^7+x^4+x^3 mod x^3+x+1 = x^2
        start_req(1, 1'b0, 5'b10011, 3'b111, 4'b1011);
        wait_done("gen1");
        check_res("gen1", 3'b100, 1'b0, 1'b1);
        release_res("gen1_rel");

        // Backpressure in DONE with both ports requesting
        start_req(0, 1'b0, 5'b11010, 3'b000, 4'b1011);
        wait_done("bp");
        valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_res("bp_hold", 3'b010, 1'b0, 1'b0);
            check("bp_ready", ready, 2'b00);
        end
        valid = 2'b00;
        release_res("bp_rel");

        // Poly and data changes after acceptance have no effect (1101 would give 000)
        start_req(0, 1'b0, 5'b11010, 3'b000, 4'b1011);
        poly = 4'b1101; data0 = 5'b00000; chk = 2'b11; crc0 = 3'b111;
        wait_done("polychg");
        check_res("polychg", 3'b010, 1'b0, 1'b0);
        release_res("polychg_rel");
        chk = 2'b00; poly = 4'b1011;

        // Reset during SHIFT cycle 4
        start_req(1, 1'b0, 5'b11010, 3'b000, 4'b1011);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 2'b00);
        check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_ready_port0", ready, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            seen = seen | res_valid;
        end
        check("midrst_no_result", seen, 0);
        start_req(0, 1'b0, 5'b10011, 3'b000, 4'b1011);
        wait_done("after_rst");
        check_res("after_rst", 3'b100, 1'b0, 1'b0);
        release_res("after_rst_rel");

        // Both ports valid continuously from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        data0 = 5'b11010; data1 = 5'b10011; chk = 2'b00; poly = 4'b1011;
        valid = 2'b11; res_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_res = 0;
        for (int c = 0; c < 80 && n_res < 4; c++) begin
            @(posedge clk); #1;
            check("arb_ready_not_both", (ready == 2'b11), 0);
            if (res_valid) begin
                ids[n_res]  = res_id;
                crcs[n_res] = res_crc;
                n_res++;
            end
        end
        valid = 2'b00; res_ready = 1'b0;
        check("arb_count", n_res, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("arb_id%0d", k),  ids[k],  k % 2);
            check($sformatf("arb_crc%0d", k), crcs[k], (k % 2 == 0) ? 3'b010 : 3'b100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
